// File: rtl/fa_nbit_ripple_reg.sv
`default_nettype none
// ============================================================================
// Module      : fa_nbit_ripple_reg (with leaf cell fa_cell)
// Description : N-bit ripple-carry adder built from a chain of N 1-bit
//               full-adder cells, followed by a registered output stage.
//               Computes {Cout,Sum} = in1 + in2 + Cin (unsigned, no
//               saturation; overflow is visible only through Cout).
//
// Ports (fa_nbit_ripple_reg)
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous, active-high reset
//   Sum        out  N  registered sum
//   Cout       out  1  registered carry out of the last cell
//   in1        in   N  operand A (unsigned)
//   in2        in   N  operand B (unsigned)
//   Cin        in   1  carry into cell 0
//   in_valid   in   1  qualifies in1/in2/Cin for capture on this edge
//   out_valid  out  1  high for one cycle per captured result
//
// Ports (fa_cell)
//   a_i, b_i, c_i  in   1  addend bits and carry in
//   s_o            out  1  sum bit      = a ^ b ^ c
//   c_o            out  1  carry out    = majority(a, b, c)
//
// Revision    : 1.0 - initial release
// ============================================================================

module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic w_prop;

  // Propagate term is shared between the sum and the carry expressions.
  assign w_prop = a_i ^ b_i;
  assign s_o    = w_prop ^ c_i;
  assign c_o    = (a_i & b_i) | (c_i & w_prop);

endmodule

module fa_nbit_ripple_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] Sum,
  output logic         Cout,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         Cin,
  input  logic         in_valid,
  output logic         out_valid
);

  // --------------------------------------------------------------------------
  // Combinational ripple-carry core
  // --------------------------------------------------------------------------
  logic [N:0]   w_carry;   // w_carry[i] is the carry into cell i
  logic [N-1:0] w_sum;
  logic         w_raw_cout;

  assign w_carry[0] = Cin;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cell
      fa_cell u_fa (
        .a_i (in1[gi]),
        .b_i (in2[gi]),
        .c_i (w_carry[gi]),
        .s_o (w_sum[gi]),
        .c_o (w_carry[gi+1])
      );
    end
  endgenerate

  assign w_raw_cout = w_carry[N];

  // --------------------------------------------------------------------------
  // Output register stage
  // --------------------------------------------------------------------------
  logic [N-1:0] sum_q,  sum_d;
  logic         cout_q, cout_d;
  logic         valid_q, valid_d;

  // Data registers load only on a qualified cycle; otherwise they hold, so
  // unknown operands presented while in_valid=0 never reach the outputs.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = w_sum;
      cout_d  = w_raw_cout;
      valid_d = 1'b1;
    end
  end

  // Reset acts immediately and discards any result about to be captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fa_nbit_ripple_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_fa_nbit_ripple_reg
// Description : Scoreboard bench for fa_nbit_ripple_reg at N=4 and N=8.
//               The stimulus process pushes expected {Cout,Sum} values,
//               computed with plain integer addition, into one queue per
//               instance; a monitor on the falling edge pops and compares
//               whenever out_valid is high, and otherwise checks that the
//               last result (or the reset value) is held.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_fa_nbit_ripple_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in1_4, in2_4;
  logic [7:0] in1_8, in2_8;
  logic       cin;
  logic       in_valid;

  logic [3:0] sum4;
  logic       cout4, ov4;
  logic [7:0] sum8;
  logic       cout8, ov8;

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0] q4[$];
  logic [8:0] q8[$];
  logic [8:0] last4 = '0;
  logic [8:0] last8 = '0;

  always #5 clk = ~clk;

  fa_nbit_ripple_reg #(.N(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .Sum       (sum4),
    .Cout      (cout4),
    .in1       (in1_4),
    .in2       (in2_4),
    .Cin       (cin),
    .in_valid  (in_valid),
    .out_valid (ov4)
  );

  fa_nbit_ripple_reg #(.N(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .Sum       (sum8),
    .Cout      (cout8),
    .in1       (in1_8),
    .in2       (in2_8),
    .Cin       (cin),
    .in_valid  (in_valid),
    .out_valid (ov8)
  );

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_hold4", {1'b0, ov4, cout4, sum4, 4'h0}, 10'h0);
      chk("rst_hold8", {ov8, cout8, sum8}, 10'h0);
    end else begin
      if (ov4) begin
        if (q4.size() == 0) chk("unexpected_valid4", 10'h1, 10'h0);
        else begin
          last4 = q4.pop_front();
          chk("result4", {5'h0, cout4, sum4}, {5'h0, last4[4:0]});
        end
      end else begin
        chk("hold4", {5'h0, cout4, sum4}, {5'h0, last4[4:0]});
      end
      if (ov8) begin
        if (q8.size() == 0) chk("unexpected_valid8", 10'h1, 10'h0);
        else begin
          last8 = q8.pop_front();
          chk("result8", {1'b0, cout8, sum8}, {1'b0, last8});
        end
      end else begin
        chk("hold8", {1'b0, cout8, sum8}, {1'b0, last8});
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c);
    int s4, s8;
    @(posedge clk);
    #1;
    in1_4    = a[3:0];
    in2_4    = b[3:0];
    in1_8    = a;
    in2_8    = b;
    cin      = c;
    in_valid = 1'b1;
    s4 = int'(a[3:0]) + int'(b[3:0]) + int'(c);
    s8 = int'(a) + int'(b) + int'(c);
    q4.push_back(9'(s4 % 32));
    q8.push_back(9'(s8 % 512));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in1_4    = 'x;
    in2_4    = 'x;
    in1_8    = 'x;
    in2_8    = 'x;
    cin      = 1'bx;
  endtask

  initial begin
    logic [31:0] r;

    // Reset with all-ones operands and in_valid high: outputs must stay 0.
    rst      = 1'b1;
    in1_4    = 4'hF;
    in2_4    = 4'hF;
    in1_8    = 8'hFF;
    in2_8    = 8'hFF;
    cin      = 1'b1;
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    idle();

    // Basic add, then hold.
    issue(8'd5, 8'd3, 1'b1);
    idle();
    idle();
    idle();

    // Async reset between edges while a result (9) is being presented.
    issue(8'd5, 8'd3, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst4", {5'h0, ov4, sum4}, 10'h0);
    chk("async_rst_cout4", {9'h0, cout4}, 10'h0);
    chk("async_rst8", {ov8, cout8, sum8}, 10'h0);
    q4.delete();
    q8.delete();
    last4 = '0;
    last8 = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();

    // Full-carry ripple cases.
    issue(8'd15, 8'd0, 1'b1);
    issue(8'd15, 8'd15, 1'b1);
    issue(8'hFF, 8'h00, 1'b1);
    issue(8'hFF, 8'hFF, 1'b1);
    idle();

    // Back-to-back stream then drop valid.
    issue(8'd1, 8'd2, 1'b0);
    issue(8'd7, 8'd8, 1'b1);
    issue(8'd0, 8'd0, 1'b0);
    idle();
    idle();
    idle();

    // Random 4-bit vectors from 9 random bits, occasional gaps.
    for (int i = 0; i < 24; i++) begin
      r = $urandom;
      issue({4'h0, r[8:5]}, {4'h0, r[4:1]}, r[0]);
      if (r[12:10] == 3'd0) idle();
    end
    idle();

    // Random full-width vectors from 17 random bits.
    for (int i = 0; i < 24; i++) begin
      r = $urandom;
      issue(r[16:9], r[8:1], r[0]);
      if (r[20:18] == 3'd0) idle();
    end
    idle();
    idle();
    idle();

    chk("drain4", 10'(q4.size()), 10'h0);
    chk("drain8", 10'(q8.size()), 10'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
